timing_generator: RTL and testbench

// - Machine-cycle timing generator for the CPU. It divides the system clock by 4 into a
//   4-phase machine cycle.
// - It produces two non-overlapping phase strobes (clk_s0, clk_s1) and a one-cycle step

---
 rtl/timing_generator_pkg.sv | 17 +
 rtl/timing_generator.sv | 47 ++++
 tb/tb_timing_generator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/timing_generator_pkg.sv
// Shared CPU timing constants: machine-cycle phase indices and cycle length.
// The control unit decodes div_count against these.
package timing_generator_pkg;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_S0   = 2'd1;
  localparam logic [1:0] PH_GAP  = 2'd2;
  localparam logic [1:0] PH_S1   = 2'd3;

  localparam int unsigned CYCLE_LEN = 4;

  // Wraps 3 -> 0 naturally through 2-bit truncation.
  function automatic logic [1:0] next_phase(input logic [1:0] phase);
    return phase + 2'd1;
  endfunction

endpackage

// File: rtl/timing_generator.sv
// Divides clk by 4 into a 4-phase machine cycle and emits registered phase strobes
// (clk_s0, clk_s1) plus a one-clk step pulse after each completed cycle.
module timing_generator
  import timing_generator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  output logic       step,
  output logic       clk_s0,
  output logic       clk_s1,
  output logic [1:0] div_count
);

  logic [1:0] count_d;
  logic       s0_d;
  logic       s1_d;
  logic       step_d;

  // Strobes decode the phase being entered, so they line up with div_count.
  always_comb begin
    count_d = next_phase(div_count);
    s0_d    = (count_d == PH_S0);
    s1_d    = (count_d == PH_S1);
    step_d  = (div_count == PH_S1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_count <= PH_IDLE;
      clk_s0    <= 1'b0;
      clk_s1    <= 1'b0;
      step      <= 1'b0;
    end else if (E) begin
      div_count <= count_d;
      clk_s0    <= s0_d;
      clk_s1    <= s1_d;
      step      <= step_d;
    end else begin
      // Frozen: phase holds, strobes and any pending step drop.
      clk_s0    <= 1'b0;
      clk_s1    <= 1'b0;
      step      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timing_generator.sv
// Randomized plus directed bench for timing_generator; a driver pushes expected outputs
// from an advance-count model into a queue, a monitor pops and compares after each edge.
module tb_timing_generator;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic       step;
  logic       clk_s0;
  logic       clk_s1;
  logic [1:0] div_count;

  timing_generator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .E         (E),
    .step      (step),
    .clk_s0    (clk_s0),
    .clk_s1    (clk_s1),
    .div_count (div_count)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  typedef struct packed {
    logic [1:0] cnt;
    logic       s0;
    logic       s1;
    logic       stp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  int   steps_seen = 0;

  // Model: number of enabled advances since the last reset.
  int unsigned k = 0;

  task automatic apply(input logic r, input logic e, input logic glitch);
    exp_t x;
    int unsigned ph;
    rst_n = r;
    E     = e;
    if (!r) begin
      k = 0;
      x = '0;
    end else if (e) begin
      k++;
      ph    = k % 4;
      x.cnt = ph[1:0];
      x.s0  = (ph == 1);
      x.s1  = (ph == 3);
      x.stp = (ph == 0);
    end else begin
      ph    = k % 4;
      x.cnt = ph[1:0];
      x.s0  = 1'b0;
      x.s1  = 1'b0;
      x.stp = 1'b0;
    end
    q.push_back(x);
    pushed++;
    if (glitch) begin
      #30 E = ~e;
      #30 E = e;
    end
    @(posedge clk);
    #20;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #10;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      popped++;
      chk("div_count", int'(div_count), int'(x.cnt));
      chk("clk_s0", int'(clk_s0), int'(x.s0));
      chk("clk_s1", int'(clk_s1), int'(x.s1));
      chk("step", int'(step), int'(x.stp));
      chk("no_overlap", int'(clk_s0 & clk_s1), 0);
      chk("step_at_zero", int'(step && (div_count != 2'd0)), 0);
      if (step) steps_seen++;
    end
  end

  initial begin
    #(200 * 5000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    E     = 1'b0;
    #20;
    // Reset hold with E toggling.
    for (int i = 0; i < 4; i++) apply(1'b0, i[0], 1'b0);
    // Free run: 12 enabled clocks, expect exactly 3 step pulses.
    base = steps_seen;
    for (int i = 0; i < 12; i++) apply(1'b1, 1'b1, 1'b0);
    chk("free_run_steps", steps_seen - base, 3);
    // Freeze at count 2, then resume.
    while (k % 4 != 2) apply(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    // Freeze while clk_s0 is high.
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    // Reset at count 3 discards the pending step.
    while (k % 4 != 3) apply(1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    // Glitches on E between edges must be ignored.
    for (int i = 0; i < 8; i++) apply(1'b1, i[1], 1'b1);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0));
    end
    chk("scoreboard_drained", popped, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
